// File: rtl/aes_decipher_sched.sv
// aes_decipher_sched
//   Round-robin scheduler that lets two independent requesters share one
//   aes_decipher_block core. A granted ciphertext block is latched into
//   core_block, the core is started with a one-cycle core_next pulse, and the
//   core's new_block is captured into the owning port's output buffer.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   s0_*/s1_*               request side: valid/ready handshake, 128-bit block
//   m0_*/m1_*               result side: registered valid/block, ready input
//   core_next, core_block   start pulse and held input block for the core
//   core_ready, core_result core status and new_block
//   owner                   port owning the core (or last owner), for key select
//   busy                    high in every state except IDLE
//   err                     sticky completion-timeout flag
//
// Configuration
//   AES_DEC_SCHED_TIMEOUT_EN  when defined, a 7-bit watchdog aborts a BUSY
//                             phase after TIMEOUT_CYCLES cycles and sets err.
//                             When undefined, err is tied to 0 and BUSY waits
//                             for core_ready indefinitely.
//
// state | meaning
// IDLE  | arbitrate between eligible ports, accept one request
// ISSUE | pulse core_next for one cycle
// BUSY  | wait for core completion (first cycle ignores core_ready)

module aes_decipher_sched #(
    parameter int TIMEOUT_CYCLES = 127
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s0_valid,
    output logic         s0_ready,
    input  logic [127:0] s0_block,
    input  logic         s1_valid,
    output logic         s1_ready,
    input  logic [127:0] s1_block,
    output logic         m0_valid,
    input  logic         m0_ready,
    output logic [127:0] m0_block,
    output logic         m1_valid,
    input  logic         m1_ready,
    output logic [127:0] m1_block,
    output logic         core_next,
    output logic [127:0] core_block,
    input  logic         core_ready,
    input  logic [127:0] core_result,
    output logic         owner,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY} state_t;

    // The watchdog counter is 7 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 127) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..127");
    end

    state_t       state_q, state_d;
    logic         rr_q, rr_d;           // 1: port 1 preferred on a tie
    logic         owner_q, owner_d;
    logic         first_q, first_d;     // first BUSY cycle
    logic [127:0] core_block_q, core_block_d;
    logic         m0_valid_q, m0_valid_d;
    logic         m1_valid_q, m1_valid_d;
    logic [127:0] m0_block_q, m0_block_d;
    logic [127:0] m1_block_q, m1_block_d;

    logic elig0, elig1, can_grant, grant0, grant1, done, timeout_hit;

    // Eligibility uses the registered buffer state only.
    assign elig0     = s0_valid & ~m0_valid_q;
    assign elig1     = s1_valid & ~m1_valid_q;
    assign can_grant = (state_q == ST_IDLE) & core_ready;
    assign grant0    = can_grant & elig0 & (~elig1 | ~rr_q);
    assign grant1    = can_grant & elig1 & (~elig0 |  rr_q);
    assign done      = (state_q == ST_BUSY) & ~first_q & core_ready;

`ifdef AES_DEC_SCHED_TIMEOUT_EN
    logic [6:0] cnt_q;
    logic       err_q;

    assign timeout_hit = (cnt_q == 7'(TIMEOUT_CYCLES - 1));

    // Holds zero outside BUSY, so it is cleared on every BUSY entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == ST_BUSY) ? cnt_q + 7'd1 : 7'd0;
            if ((state_q == ST_BUSY) && !done && timeout_hit)
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        owner_d      = owner_q;
        first_d      = 1'b0;
        core_block_d = core_block_q;
        m0_valid_d   = m0_valid_q;
        m1_valid_d   = m1_valid_q;
        m0_block_d   = m0_block_q;
        m1_block_d   = m1_block_q;

        if (m0_valid_q && m0_ready) m0_valid_d = 1'b0;
        if (m1_valid_q && m1_ready) m1_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant0) begin
                    core_block_d = s0_block;
                    owner_d      = 1'b0;
                    rr_d         = 1'b1;
                    state_d      = ST_ISSUE;
                end else if (grant1) begin
                    core_block_d = s1_block;
                    owner_d      = 1'b1;
                    rr_d         = 1'b0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                first_d = 1'b1;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                // The owner's buffer is known empty here, so no clear can collide.
                if (done) begin
                    state_d = ST_IDLE;
                    if (owner_q) begin
                        m1_block_d = core_result;
                        m1_valid_d = 1'b1;
                    end else begin
                        m0_block_d = core_result;
                        m0_valid_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rr_q         <= 1'b0;
            owner_q      <= 1'b0;
            first_q      <= 1'b0;
            core_block_q <= '0;
            m0_valid_q   <= 1'b0;
            m1_valid_q   <= 1'b0;
            m0_block_q   <= '0;
            m1_block_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            owner_q      <= owner_d;
            first_q      <= first_d;
            core_block_q <= core_block_d;
            m0_valid_q   <= m0_valid_d;
            m1_valid_q   <= m1_valid_d;
            m0_block_q   <= m0_block_d;
            m1_block_q   <= m1_block_d;
        end
    end

    assign s0_ready   = grant0;
    assign s1_ready   = grant1;
    assign m0_valid   = m0_valid_q;
    assign m1_valid   = m1_valid_q;
    assign m0_block   = m0_block_q;
    assign m1_block   = m1_block_q;
    assign core_next  = (state_q == ST_ISSUE);
    assign core_block = core_block_q;
    assign owner      = owner_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_decipher_sched.sv
// Bench for aes_decipher_sched with a behavioural core model. The model
// returns the FIPS-197 AES-128 plaintext for the FIPS-197 ciphertext
// (key 000102..0f) and block ^ {16{8'h5a}} for any other block.

module tb_aes_decipher_sched;

    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] MASK = {16{8'h5a}};
    localparam int           LAT  = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         s0_valid = 1'b0, s1_valid = 1'b0;
    logic         s0_ready, s1_ready;
    logic [127:0] s0_block = '0, s1_block = '0;
    logic         m0_valid, m1_valid;
    logic         m0_ready = 1'b0, m1_ready = 1'b0;
    logic [127:0] m0_block, m1_block;
    logic         core_next;
    logic [127:0] core_block;
    logic         core_ready;
    logic [127:0] core_result;
    logic         owner, busy, err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aes_decipher_sched #(.TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_block(s0_block),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_block(s1_block),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_block(m0_block),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_block(m1_block),
        .core_next(core_next), .core_block(core_block),
        .core_ready(core_ready), .core_result(core_result),
        .owner(owner), .busy(busy), .err(err)
    );

    // ---------------- core model ----------------
    bit           hang = 1'b0;
    logic         next_d;
    logic [127:0] core_in;
    int           core_cnt;

    function automatic logic [127:0] core_fn(input logic [127:0] b);
        if (b == CT) return PT;
        return b ^ MASK;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_ready  <= 1'b1;
            core_result <= '0;
            core_cnt    <= 0;
            next_d      <= 1'b0;
            core_in     <= '0;
        end else begin
            next_d <= core_next;
            if (next_d) core_in <= core_block;
            if (core_next) begin
                core_ready <= 1'b0;
                core_cnt   <= LAT;
            end else if (!core_ready && !hang) begin
                if (core_cnt == 0) begin
                    core_ready  <= 1'b1;
                    core_result <= core_fn(core_in);
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int id, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, id, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0;
        m0_ready = 1'b0; m1_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Request on a port; returns at the negedge of the ISSUE cycle.
    task automatic send(input int port, input logic [127:0] blk, input int id);
        int  n;
        bit  rdy;
        @(negedge clk);
        if (port == 0) begin s0_valid = 1'b1; s0_block = blk; end
        else           begin s1_valid = 1'b1; s1_block = blk; end
        #1;
        n = 0;
        rdy = (port == 0) ? s0_ready : s1_ready;
        while (!rdy && n < 200) begin
            @(negedge clk); #1;
            rdy = (port == 0) ? s0_ready : s1_ready;
            n++;
        end
        chk("grant", id, 128'(rdy), 128'(1));
        @(posedge clk); #1;
        if (port == 0) s0_valid = 1'b0; else s1_valid = 1'b0;
        @(negedge clk);
        chk("core_next", id, 128'(core_next), 128'(1));
        chk("owner", id, 128'(owner), 128'(port));
        chk("core_block", id, core_block, blk);
    endtask

    // Waits for a port's result, checks its timing and value, optionally drains.
    task automatic collect(input int port, input logic [127:0] exp, input int id,
                           input bit drain);
        int   n;
        logic v, prev_rdy;
        n = 0;
        prev_rdy = 1'b0;
        v = (port == 0) ? m0_valid : m1_valid;
        while (!v && n < 200) begin
            prev_rdy = core_ready;
            @(negedge clk);
            v = (port == 0) ? m0_valid : m1_valid;
            n++;
        end
        chk("m_valid_seen", id, 128'(v), 128'(1));
        chk("ready_before_valid", id, 128'(prev_rdy), 128'(1));
        chk("m_block", id, (port == 0) ? m0_block : m1_block, exp);
        if (drain) begin
            if (port == 0) m0_ready = 1'b1; else m1_ready = 1'b1;
            @(negedge clk);
            chk("m_valid_cleared", id, 128'((port == 0) ? m0_valid : m1_valid), 128'(0));
            m0_ready = 1'b0; m1_ready = 1'b0;
        end
    endtask

    typedef struct {
        int           port;
        logic [127:0] blk;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   grants[4];
        int   exp_g[4];
        int   ng, cyc, pend, nb;

        vecs[0] = '{0, CT, PT};
        vecs[1] = '{1, 128'h0, MASK};
        vecs[2] = '{0, {128{1'b1}}, {16{8'ha5}}};
        vecs[3] = '{1, MASK, 128'h0};
        vecs[4] = '{0, 128'h0123456789abcdef_fedcba9876543210,
                       128'h5b791f3dd3f197b5_a486e0c22c0e684a};
        vecs[5] = '{1, CT, PT};

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_m0_valid", 0, 128'(m0_valid), 128'(0));
        chk("rst_m1_valid", 0, 128'(m1_valid), 128'(0));
        chk("rst_m0_block", 0, m0_block, 128'h0);
        chk("rst_m1_block", 0, m1_block, 128'h0);
        chk("rst_core_next", 0, 128'(core_next), 128'(0));
        chk("rst_core_block", 0, core_block, 128'h0);
        chk("rst_owner", 0, 128'(owner), 128'(0));
        chk("rst_busy", 0, 128'(busy), 128'(0));
        chk("rst_err", 0, 128'(err), 128'(0));
        chk("rst_s_ready", 0, 128'({s0_ready, s1_ready}), 128'(0));
        reset_n = 1'b1;

        // Same-cycle ready, core_next one cycle after handshake, pulse width
        @(negedge clk);
        s0_valid = 1'b1; s0_block = CT;
        #1;
        chk("s0_ready_same_cycle", 0, 128'(s0_ready), 128'(1));
        @(posedge clk); #1;
        s0_valid = 1'b0;
        @(negedge clk);
        chk("next_after_hs", 0, 128'(core_next), 128'(1));
        chk("busy_issue", 0, 128'(busy), 128'(1));
        @(negedge clk);
        chk("next_one_cycle", 0, 128'(core_next), 128'(0));
        collect(0, PT, 0, 1'b1);

        // Table of single transactions, alternating ports
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].port, vecs[i].blk, 10 + i);
            collect(vecs[i].port, vecs[i].exp, 10 + i, 1'b1);
        end

        // Simultaneous requests: grants alternate starting with port 0
        do_reset();
        exp_g = '{0, 1, 0, 1};
        @(negedge clk);
        s0_valid = 1'b1; s0_block = 128'h1;
        s1_valid = 1'b1; s1_block = 128'h2;
        m0_ready = 1'b1; m1_ready = 1'b1;
        ng = 0; cyc = 0; pend = -1;
        while (ng < 4 && cyc < 400) begin
            #1;
            if (pend >= 0) begin
                chk("rr_owner", 20 + ng, 128'(owner), 128'(pend));
                pend = -1;
            end
            if (s0_ready || s1_ready) begin
                grants[ng] = s1_ready ? 1 : 0;
                pend = grants[ng];
                ng++;
            end
            @(negedge clk);
            cyc++;
        end
        #1;
        if (pend >= 0) chk("rr_owner", 20 + ng, 128'(owner), 128'(pend));
        s0_valid = 1'b0; s1_valid = 1'b0;
        chk("rr_grant_count", 20, 128'(ng), 128'(4));
        for (int i = 0; i < 4; i++)
            chk("rr_grant", 20 + i, 128'(grants[i]), 128'(exp_g[i]));
        cyc = 0;
        while (busy && cyc < 200) begin @(negedge clk); cyc++; end
        @(negedge clk);
        @(negedge clk);
        m0_ready = 1'b0; m1_ready = 1'b0;

        // Backpressure on port 0
        do_reset();
        send(0, 128'h10, 30);
        collect(0, 128'h10 ^ MASK, 30, 1'b0);
        @(negedge clk);
        s0_valid = 1'b1; s0_block = 128'h20;
        s1_valid = 1'b1; s1_block = 128'h30;
        #1;
        chk("bp_s0_blocked", 31, 128'(s0_ready), 128'(0));
        chk("bp_s1_served", 31, 128'(s1_ready), 128'(1));
        @(posedge clk); #1;
        s1_valid = 1'b0;
        collect(1, 128'h30 ^ MASK, 32, 1'b1);
        #1;
        chk("bp_s0_still_blocked", 33, 128'(s0_ready), 128'(0));
        chk("bp_m0_held", 33, m0_block, 128'h10 ^ MASK);
        chk("bp_m0_valid_held", 33, 128'(m0_valid), 128'(1));
        m0_ready = 1'b1;
        @(negedge clk);
        m0_ready = 1'b0;
        #1;
        chk("bp_s0_granted_next", 34, 128'(s0_ready), 128'(1));
        @(posedge clk); #1;
        s0_valid = 1'b0;
        collect(0, 128'h20 ^ MASK, 35, 1'b1);

        // Reset during BUSY, then a clean transaction
        do_reset();
        send(0, 128'h40, 40);
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy_before", 40, 128'(busy), 128'(1));
        reset_n = 1'b0;
        #1;
        chk("mid_busy", 41, 128'(busy), 128'(0));
        chk("mid_core_next", 41, 128'(core_next), 128'(0));
        chk("mid_m_valid", 41, 128'({m0_valid, m1_valid}), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        send(1, CT, 42);
        collect(1, PT, 42, 1'b1);

`ifdef AES_DEC_SCHED_TIMEOUT_EN
        // Core never completes: watchdog fires after 20 BUSY cycles
        do_reset();
        hang = 1'b1;
        send(0, 128'h50, 50);
        nb = 0; cyc = 0;
        while (!err && cyc < 100) begin
            @(negedge clk);
            if (!err && busy && !core_next) nb++;
            cyc++;
        end
        chk("to_err", 50, 128'(err), 128'(1));
        chk("to_busy_cycles", 50, 128'(nb), 128'(20));
        chk("to_idle", 50, 128'(busy), 128'(0));
        chk("to_no_result", 50, 128'(m0_valid), 128'(0));
        hang = 1'b0;
        repeat (10) @(negedge clk);
        chk("to_err_sticky", 51, 128'(err), 128'(1));
        chk("to_no_late_result", 51, 128'(m0_valid), 128'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
